// File: rtl/meikyuu_room_ctrl.sv
// Room-transition controller: detects screen-edge exits once per frame and
// sequences a blanked move into the neighbouring room of the 3x3 maze.
module meikyuu_room_ctrl #(
    parameter int X_MIN        = 97,
    parameter int X_MAX        = 720,
    parameter int Y_MIN        = 3,
    parameter int Y_MAX        = 466,
    parameter int ENTRY_MARGIN = 8,
    parameter int TRANS_FRAMES = 4,
    parameter int START_X      = 1,
    parameter int START_Y      = 1,
    parameter int GOAL_X       = 2,
    parameter int GOAL_Y       = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       restart,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [1:0] room_x,
    output logic [1:0] room_y,
    output logic [3:0] room_type,
    output logic       pos_load,
    output logic [9:0] pos_x_new,
    output logic [9:0] pos_y_new,
    output logic       move_en,
    output logic       blank,
    output logic       win
);

    localparam logic [9:0] X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0] X_MAX_V   = 10'(X_MAX);
    localparam logic [9:0] Y_MIN_V   = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_V   = 10'(Y_MAX);
    localparam logic [9:0] LEFT_ENTRY_X  = 10'(X_MAX - ENTRY_MARGIN);
    localparam logic [9:0] RIGHT_ENTRY_X = 10'(X_MIN + ENTRY_MARGIN);
    localparam logic [9:0] UP_ENTRY_Y    = 10'(Y_MAX - ENTRY_MARGIN);
    localparam logic [9:0] DOWN_ENTRY_Y  = 10'(Y_MIN + ENTRY_MARGIN);
    localparam logic [9:0] RESTART_X = 10'd408;
    localparam logic [9:0] RESTART_Y = 10'd234;
    localparam logic [3:0] TRANS_V   = 4'(TRANS_FRAMES);
    localparam logic [1:0] START_X_V = 2'(START_X);
    localparam logic [1:0] START_Y_V = 2'(START_Y);
    localparam logic [1:0] GOAL_X_V  = 2'(GOAL_X);
    localparam logic [1:0] GOAL_Y_V  = 2'(GOAL_Y);

    // Indexed by {row, col}; column 3 of each row is unused padding.
    localparam logic [3:0] ROOM_TABLE [16] = '{
        4'd10, 4'd11, 4'd8, 4'd0,
        4'd0,  4'd6,  4'd0, 4'd0,
        4'd3,  4'd9,  4'd2, 4'd0,
        4'd0,  4'd0,  4'd0, 4'd0
    };

    typedef enum logic [2:0] {SETTLE, PLAY, BLANK, LOAD, WIN} state_t;

    state_t     state_reg, state_next;
    logic [1:0] room_x_reg, room_x_next;
    logic [1:0] room_y_reg, room_y_next;
    logic [3:0] room_type_reg, room_type_next;
    logic [1:0] tgt_x_reg, tgt_x_next;
    logic [1:0] tgt_y_reg, tgt_y_next;
    logic [9:0] ent_x_reg, ent_x_next;
    logic [9:0] ent_y_reg, ent_y_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       pos_load_reg, pos_load_next;
    logic [9:0] pos_x_reg, pos_x_next;
    logic [9:0] pos_y_reg, pos_y_next;
    logic       move_en_reg, move_en_next;
    logic       blank_reg, blank_next;
    logic       win_reg, win_next;

    logic       exit_hit;
    logic [1:0] exit_tx, exit_ty;
    logic [9:0] exit_px, exit_py;

    // Exit decode: only the highest-priority edge is considered, so an
    // off-grid left exit does not fall through to a lower-priority edge.
    always_comb begin
        exit_hit = 1'b0;
        exit_tx  = room_x_reg;
        exit_ty  = room_y_reg;
        exit_px  = player_x;
        exit_py  = player_y;
        if (player_x <= X_MIN_V) begin
            exit_hit = (room_x_reg != 2'd0);
            exit_tx  = room_x_reg - 2'd1;
            exit_px  = LEFT_ENTRY_X;
        end else if (player_x >= X_MAX_V) begin
            exit_hit = (room_x_reg < 2'd2);
            exit_tx  = room_x_reg + 2'd1;
            exit_px  = RIGHT_ENTRY_X;
        end else if (player_y <= Y_MIN_V) begin
            exit_hit = (room_y_reg != 2'd0);
            exit_ty  = room_y_reg - 2'd1;
            exit_py  = UP_ENTRY_Y;
        end else if (player_y >= Y_MAX_V) begin
            exit_hit = (room_y_reg < 2'd2);
            exit_ty  = room_y_reg + 2'd1;
            exit_py  = DOWN_ENTRY_Y;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tgt_x_next     = tgt_x_reg;
        tgt_y_next     = tgt_y_reg;
        ent_x_next     = ent_x_reg;
        ent_y_next     = ent_y_reg;
        cnt_next       = cnt_reg;
        room_x_next    = room_x_reg;
        room_y_next    = room_y_reg;
        room_type_next = room_type_reg;
        pos_x_next     = pos_x_reg;
        pos_y_next     = pos_y_reg;

        case (state_reg)
            SETTLE: begin
                if (frame_start) begin
                    if (room_x_reg == GOAL_X_V && room_y_reg == GOAL_Y_V)
                        state_next = WIN;
                    else
                        state_next = PLAY;
                end
            end
            PLAY: begin
                if (frame_start && exit_hit) begin
                    tgt_x_next = exit_tx;
                    tgt_y_next = exit_ty;
                    ent_x_next = exit_px;
                    ent_y_next = exit_py;
                    cnt_next   = 4'd0;
                    state_next = BLANK;
                end
            end
            BLANK: begin
                if (frame_start) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg + 4'd1 == TRANS_V)
                        state_next = LOAD;
                end
            end
            LOAD:    state_next = SETTLE;
            WIN:     state_next = WIN;
            default: state_next = SETTLE;
        endcase

        if (restart) begin
            tgt_x_next = START_X_V;
            tgt_y_next = START_Y_V;
            ent_x_next = RESTART_X;
            ent_y_next = RESTART_Y;
            cnt_next   = 4'd0;
            state_next = BLANK;
        end

        // Outputs are registered from the next state so they move one edge
        // after the cause; the room and strobe change together on entering LOAD.
        if (state_next == LOAD) begin
            room_x_next    = tgt_x_next;
            room_y_next    = tgt_y_next;
            room_type_next = ROOM_TABLE[{tgt_y_next, tgt_x_next}];
            pos_x_next     = ent_x_next;
            pos_y_next     = ent_y_next;
        end
        pos_load_next = (state_next == LOAD);
        move_en_next  = (state_next == PLAY);
        blank_next    = (state_next == SETTLE) || (state_next == BLANK) ||
                        (state_next == LOAD);
        win_next      = (state_next == WIN);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg     <= SETTLE;
            room_x_reg    <= START_X_V;
            room_y_reg    <= START_Y_V;
            room_type_reg <= ROOM_TABLE[{START_Y_V, START_X_V}];
            tgt_x_reg     <= START_X_V;
            tgt_y_reg     <= START_Y_V;
            ent_x_reg     <= 10'd0;
            ent_y_reg     <= 10'd0;
            cnt_reg       <= 4'd0;
            pos_load_reg  <= 1'b0;
            pos_x_reg     <= 10'd0;
            pos_y_reg     <= 10'd0;
            move_en_reg   <= 1'b0;
            blank_reg     <= 1'b1;
            win_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            room_x_reg    <= room_x_next;
            room_y_reg    <= room_y_next;
            room_type_reg <= room_type_next;
            tgt_x_reg     <= tgt_x_next;
            tgt_y_reg     <= tgt_y_next;
            ent_x_reg     <= ent_x_next;
            ent_y_reg     <= ent_y_next;
            cnt_reg       <= cnt_next;
            pos_load_reg  <= pos_load_next;
            pos_x_reg     <= pos_x_next;
            pos_y_reg     <= pos_y_next;
            move_en_reg   <= move_en_next;
            blank_reg     <= blank_next;
            win_reg       <= win_next;
        end
    end

    assign room_x    = room_x_reg;
    assign room_y    = room_y_reg;
    assign room_type = room_type_reg;
    assign pos_load  = pos_load_reg;
    assign pos_x_new = pos_x_reg;
    assign pos_y_new = pos_y_reg;
    assign move_en   = move_en_reg;
    assign blank     = blank_reg;
    assign win       = win_reg;

endmodule
